// File: rtl/edge_event_reporter.sv
// Debounces the lowest flagged row and queues FOUND/MOVED/LOST events.
// Optional EDGE_TIMESTAMP_EN adds a 16-bit sample timestamp per event.
module edge_event_reporter #(
  parameter int PIXEL_HEIGHT = 8,
  parameter int PERSIST      = 3,
  parameter int FIFO_DEPTH   = 4,
  localparam int POS_W = $clog2(PIXEL_HEIGHT),
  localparam int CNT_W = $clog2(PIXEL_HEIGHT + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [PIXEL_HEIGHT-1:0] in_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_type,
  output logic [POS_W-1:0]        out_position,
  output logic [CNT_W-1:0]        out_count,
  output logic                    overflow
`ifdef EDGE_TIMESTAMP_EN
  ,
  output logic [15:0]             out_timestamp
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] EV_FOUND = 2'b01;
  localparam logic [1:0] EV_MOVED = 2'b10;
  localparam logic [1:0] EV_LOST  = 2'b11;
  localparam bit ONE_SHOT = (PERSIST == 1);

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED
  } state_t;

  typedef struct packed {
    logic [1:0]       typ;
    logic [POS_W-1:0] pos;
    logic [CNT_W-1:0] cnt;
`ifdef EDGE_TIMESTAMP_EN
    logic [15:0]      ts;
`endif
  } ev_t;

  logic [POS_W-1:0] f_pos;
  logic [CNT_W-1:0] f_cnt;

  always_comb begin
    f_pos = '0;
    f_cnt = '0;
    for (int i = PIXEL_HEIGHT - 1; i >= 0; i--)
      if (in_flags[i]) f_pos = POS_W'(i);
    for (int i = 0; i < PIXEL_HEIGHT; i++)
      f_cnt = f_cnt + CNT_W'(in_flags[i]);
  end

  logic             s1_valid;
  logic             s1_any;
  logic [POS_W-1:0] s1_pos;
  logic [CNT_W-1:0] s1_cnt;
`ifdef EDGE_TIMESTAMP_EN
  logic [15:0]      ts_cnt;
  logic [15:0]      s1_ts;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_any   <= 1'b0;
      s1_pos   <= '0;
      s1_cnt   <= '0;
`ifdef EDGE_TIMESTAMP_EN
      ts_cnt   <= '0;
      s1_ts    <= '0;
`endif
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_any <= |in_flags;
        s1_pos <= f_pos;
        s1_cnt <= f_cnt;
`ifdef EDGE_TIMESTAMP_EN
        s1_ts  <= ts_cnt;
        ts_cnt <= ts_cnt + 16'd1;
`endif
      end
    end
  end

  state_t           state;
  logic             have_lock;
  logic [POS_W-1:0] held_pos;
  logic [POS_W-1:0] locked_pos;
  logic [7:0]       pcnt;
  logic [7:0]       miss;
  logic [8:0]       p_next;
  logic [8:0]       m_next;
  logic             confirm;
  logic             lost;
  logic             ev_push;
  ev_t              ev;

  // An event is decided in the same cycle the FSM consumes the sample.
  always_comb begin
    p_next  = {1'b0, pcnt} + 9'd1;
    m_next  = {1'b0, miss} + 9'd1;
    confirm = 1'b0;
    lost    = 1'b0;
    if (s1_valid) begin
      unique case (state)
        SEARCH:  confirm = s1_any && ONE_SHOT;
        CONFIRM: begin
          if (s1_any && s1_pos == held_pos)
            confirm = p_next >= 9'(PERSIST);
          else if (s1_any)
            confirm = ONE_SHOT;
        end
        LOCKED: begin
          confirm = s1_any && s1_pos != locked_pos && ONE_SHOT;
          lost    = !s1_any && m_next >= 9'(PERSIST);
        end
        default: ;
      endcase
    end
    ev_push = confirm || lost;
    ev.typ  = lost ? EV_LOST : (have_lock ? EV_MOVED : EV_FOUND);
    ev.pos  = lost ? locked_pos : s1_pos;
    ev.cnt  = lost ? '0 : s1_cnt;
`ifdef EDGE_TIMESTAMP_EN
    ev.ts   = s1_ts;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= SEARCH;
      have_lock  <= 1'b0;
      held_pos   <= '0;
      locked_pos <= '0;
      pcnt       <= '0;
      miss       <= '0;
    end else if (s1_valid) begin
      if (confirm) begin
        state      <= LOCKED;
        locked_pos <= s1_pos;
        have_lock  <= 1'b1;
        miss       <= '0;
        pcnt       <= '0;
      end else if (lost) begin
        state     <= SEARCH;
        have_lock <= 1'b0;
        miss      <= '0;
      end else begin
        unique case (state)
          SEARCH: begin
            if (s1_any) begin
              state    <= CONFIRM;
              held_pos <= s1_pos;
              pcnt     <= 8'd1;
            end
          end
          CONFIRM: begin
            if (s1_any && s1_pos == held_pos) begin
              pcnt <= pcnt + 8'd1;
            end else if (s1_any) begin
              held_pos <= s1_pos;
              pcnt     <= 8'd1;
            end else if (!have_lock) begin
              state <= SEARCH;
            end else begin
              state <= LOCKED;
              miss  <= 8'd1;
            end
          end
          LOCKED: begin
            if (s1_any && s1_pos == locked_pos) begin
              miss <= '0;
            end else if (s1_any) begin
              state    <= CONFIRM;
              held_pos <= s1_pos;
              pcnt     <= 8'd1;
            end else begin
              miss <= miss + 8'd1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  ev_t         mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        pop;
  logic        do_push;
  ev_t         head;

  assign out_valid = wr_ptr != rd_ptr;
  assign full      = wr_ptr[AW] != rd_ptr[AW] &&
                     wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign pop       = out_valid && out_ready;
  assign do_push   = ev_push && (!full || pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= ev;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ev_push && !do_push) overflow <= 1'b1;
    end
  end

  assign head         = mem[rd_ptr[AW-1:0]];
  assign out_type     = out_valid ? head.typ : '0;
  assign out_position = out_valid ? head.pos : '0;
  assign out_count    = out_valid ? head.cnt : '0;
`ifdef EDGE_TIMESTAMP_EN
  assign out_timestamp = out_valid ? head.ts : '0;
`endif

endmodule

// File: tb/tb_edge_event_reporter.sv
// Random and directed bench for edge_event_reporter with a queue model.
// Timestamp checks are enabled when EDGE_TIMESTAMP_EN is defined.
module tb_edge_event_reporter;

  localparam int PH = 8;
  localparam int P  = 3;
  localparam int FD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_flags = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_type;
  logic [2:0] out_position;
  logic [3:0] out_count;
  logic       overflow;
`ifdef EDGE_TIMESTAMP_EN
  logic [15:0] out_timestamp;
`endif

  edge_event_reporter #(
    .PIXEL_HEIGHT(PH),
    .PERSIST(P),
    .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_flags(in_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_type(out_type),
    .out_position(out_position),
    .out_count(out_count),
    .overflow(overflow)
`ifdef EDGE_TIMESTAMP_EN
    ,
    .out_timestamp(out_timestamp)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int typ;
    int pos;
    int cnt;
    int ts;
  } ev_s;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: rule-level tracking of the debounce plus an event queue.
  ev_s        q[$];
  int         m_mode;
  bit         m_lock;
  int         m_held, m_locked, m_pcnt, m_miss;
  bit         m_ovf;
  bit         pend_v;
  logic [7:0] pend_f;
  int         pend_ts;
  int         m_ts;

  function automatic int lowest(input logic [7:0] f);
    for (int i = 0; i < PH; i++) if (f[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_lock = 0;
    m_held = 0; m_locked = 0;
    m_pcnt = 0; m_miss = 0;
    m_ovf = 0; pend_v = 0;
    pend_f = '0; pend_ts = 0; m_ts = 0;
  endtask

  task automatic try_confirm(input int c, inout bit ev, inout ev_s e);
    if (m_pcnt >= P) begin
      ev = 1;
      e = '{m_lock ? 2 : 1, m_held, c, pend_ts};
      m_locked = m_held; m_lock = 1;
      m_mode = 2; m_miss = 0;
    end
  endtask

  task automatic model_sample(output bit ev, output ev_s e);
    bit any = pend_f != 0;
    int pos = lowest(pend_f);
    int c = $countones(pend_f);
    ev = 0;
    e = '{0, 0, 0, 0};
    case (m_mode)
      0: if (any) begin
        m_held = pos; m_pcnt = 1; m_mode = 1;
        try_confirm(c, ev, e);
      end
      1: if (any) begin
        if (pos == m_held) m_pcnt++;
        else begin m_held = pos; m_pcnt = 1; end
        try_confirm(c, ev, e);
      end else if (!m_lock) m_mode = 0;
      else begin m_mode = 2; m_miss = 1; end
      default: if (any) begin
        if (pos == m_locked) m_miss = 0;
        else begin
          m_mode = 1; m_held = pos; m_pcnt = 1;
          try_confirm(c, ev, e);
        end
      end else begin
        m_miss++;
        if (m_miss >= P) begin
          ev = 1;
          e = '{3, m_locked, 0, pend_ts};
          m_lock = 0; m_mode = 0; m_miss = 0;
        end
      end
    endcase
  endtask

  task automatic model_edge();
    bit ev;
    ev_s e;
    if (reset) begin
      model_reset();
      return;
    end
    ev = 0;
    if (pend_v) model_sample(ev, e);
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (ev) begin
      if (q.size() < FD) q.push_back(e);
      else m_ovf = 1;
    end
    pend_v = in_valid;
    if (in_valid) begin
      pend_f = in_flags;
      pend_ts = m_ts;
      m_ts = (m_ts + 1) & 16'hFFFF;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (q.size() != 0) begin
      chk("out_type", int'(out_type), q[0].typ);
      chk("out_position", int'(out_position), q[0].pos);
      chk("out_count", int'(out_count), q[0].cnt);
`ifdef EDGE_TIMESTAMP_EN
      chk("out_timestamp", int'(out_timestamp), q[0].ts);
`endif
    end
  endtask

  task automatic step(input bit v, input logic [7:0] f, input bit r);
    in_valid = v;
    in_flags = f;
    out_ready = r;
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic samples(input int n, input logic [7:0] f, input bit r);
    for (int i = 0; i < n; i++) step(1'b1, f, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  logic [7:0] pick;

  initial begin
    model_reset();
    do_reset();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_type", int'(out_type), 0);
    chk("rst_pos", int'(out_position), 0);
    chk("rst_count", int'(out_count), 0);

    samples(3, 8'h10, 1'b0);
    chk("found_pre_valid", int'(out_valid), 0);
    step(1'b0, 8'h00, 1'b0);
    chk("found_type", int'(out_type), 1);
    chk("found_pos", int'(out_position), 4);
    chk("found_cnt", int'(out_count), 1);
    step(1'b0, 8'h00, 1'b1);

    samples(3, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("lost_type", int'(out_type), 3);
    chk("lost_pos", int'(out_position), 4);
    chk("lost_cnt", int'(out_count), 0);
    step(1'b0, 8'h00, 1'b1);
    samples(2, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("refound_early", int'(out_valid), 0);
    samples(1, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("refound_type", int'(out_type), 1);
    step(1'b0, 8'h00, 1'b1);

    samples(3, 8'h0C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("moved_type", int'(out_type), 2);
    chk("moved_pos", int'(out_position), 2);
    chk("moved_cnt", int'(out_count), 2);
    step(1'b0, 8'h00, 1'b1);

    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, i[0] ? 8'h20 : 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("alt_no_event", int'(out_valid), 0);

    do_reset();
    for (int k = 0; k < 5; k++) samples(3, k[0] ? 8'h00 : 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_head", int'(out_type), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("ovf_drained", int'(out_valid), 0);
    chk("ovf_sticky", int'(overflow), 1);

    samples(3, 8'h00, 1'b0);
    samples(3, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("two_queued", int'(out_valid), 1);
    do_reset();
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_ovf", int'(overflow), 0);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h10, 1'b0);
      for (int g = 0; g < 3; g++) step(1'b0, 8'h01, 1'b0);
    end
    chk("gap_found", int'(out_type), 1);
    step(1'b0, 8'h00, 1'b1);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0: pick = 8'h00;
        1: pick = 8'h10;
        2: pick = 8'h0C;
        3: pick = 8'h20;
        default: pick = 8'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, pick, $urandom_range(0, 9) < 6);
    end

`ifdef EDGE_TIMESTAMP_EN
    do_reset();
    samples(65534, 8'h00, 1'b1);
    samples(3, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("ts_wrap", int'(out_timestamp), 0);
    step(1'b0, 8'h00, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
